// File: rtl/local_mem_port_adapter_pkg.sv
// Shared types for the local BRAM port adapter: request/response bundles and default geometry.
package local_mem_port_adapter_pkg;

   localparam int LM_LINES  = 4096;
   localparam int LM_AW     = $clog2(LM_LINES);
   localparam int LM_ID_W   = 2;
   localparam int LM_DATA_W = 32;
   localparam int LM_BE_W   = LM_DATA_W / 8;

   typedef struct packed {
      logic                 we;
      logic [LM_AW-1:0]     addr;
      logic [LM_BE_W-1:0]   be;
      logic [LM_DATA_W-1:0] data;
      logic [LM_ID_W-1:0]   id;
   } local_mem_req_t;

   typedef struct packed {
      logic [LM_DATA_W-1:0] data;
      logic [LM_ID_W-1:0]   id;
   } local_mem_rsp_t;

endpackage

// File: rtl/local_mem_rsp_fifo.sv
// Small response FIFO holding load data and tags; the head entry is presented combinationally.
module local_mem_rsp_fifo
   import local_mem_port_adapter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  local_mem_rsp_t push_entry,
   input  logic           pop,
   output local_mem_rsp_t head,
   output logic           full,
   output logic           empty,
   output logic [CW-1:0]  count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   local_mem_rsp_t entry_reg [DEPTH];
   logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]  count_reg, count_next;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PW'(gi)))
               entry_reg[gi] <= push_entry;
         end
      end
   endgenerate

   // Pointers wrap explicitly so non-power-of-two depths behave.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push)
         wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      if (pop)
         rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      if (push && !pop)
         count_next = count_reg + CW'(1);
      else if (pop && !push)
         count_next = count_reg - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   assign head  = entry_reg[rd_ptr_reg];
   assign count = count_reg;
   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/local_mem_port_adapter.sv
// Request-side adapter for one byte-enable BRAM port: in-order load/store issue with
// credit-gated loads so every read result always has a response FIFO slot waiting.
module local_mem_port_adapter
   import local_mem_port_adapter_pkg::*;
#(
   parameter int LINES      = LM_LINES,
   parameter int RESP_DEPTH = 2,
   parameter int ID_W       = LM_ID_W,
   parameter int AW         = $clog2(LINES)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [3:0]      req_be,
   input  logic [31:0]     req_data,
   input  logic [ID_W-1:0] req_id,
   output logic [AW-1:0]   ram_addr,
   output logic            ram_en,
   output logic [3:0]      ram_be,
   output logic [31:0]     ram_data_in,
   input  logic [31:0]     ram_data_out,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [31:0]     rsp_data,
   output logic [ID_W-1:0] rsp_id
);

   localparam int CW = $clog2(RESP_DEPTH + 1);

   local_mem_req_t  req;
   local_mem_rsp_t  push_entry, head;
   logic            issue, pop, load_ok;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     occ, occ_after_pop;
   logic            rd_pending_reg;
   logic [ID_W-1:0] id_pending_reg;

   assign req = '{we: req_we, addr: req_addr, be: req_be, data: req_data, id: req_id};

   // Credits count buffered entries plus the read whose data lands next cycle.
   assign pop           = rsp_valid & rsp_ready;
   assign occ           = {1'b0, fifo_count} + (CW+1)'(rd_pending_reg);
   assign occ_after_pop = occ - (CW+1)'(pop);
   assign load_ok       = occ_after_pop < (CW+1)'(RESP_DEPTH);

   assign req_ready   = ~rst & (req.we | load_ok);
   assign issue       = req_valid & req_ready;
   assign ram_en      = issue;
   assign ram_addr    = req.addr;
   assign ram_data_in = req.data;
   assign ram_be      = (req.we & ~rst) ? req.be : 4'b0000;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pending_reg <= 1'b0;
         id_pending_reg <= '0;
      end else begin
         rd_pending_reg <= issue & ~req.we;
         id_pending_reg <= req.id;
      end
   end

   assign push_entry = '{data: ram_data_out, id: id_pending_reg};

   local_mem_rsp_fifo #(
      .DEPTH (RESP_DEPTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (rd_pending_reg),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   assign rsp_valid = ~fifo_empty;
   assign rsp_data  = head.data;
   assign rsp_id    = head.id;

   a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
      rd_pending_reg |-> !fifo_full);

   a_head_stable_when_stalled : assert property (@(posedge clk) disable iff (rst)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule
